// File: rtl/seg7_scan_driver_if.sv
// Load handshake and display-pin bundle for seg7_scan_driver.
// The master drives the value/load side; the slave (the driver) owns the pins.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 14
);
    logic [BIN_WIDTH-1:0]  i_value;
    logic                  i_load;
    logic                  i_hex_mode;
    logic [NUM_DIGITS-1:0] i_dots;
    logic                  o_busy;
    logic                  o_overflow;
    logic [0:6]            o_segment_enable;
    logic [0:NUM_DIGITS-1] o_display_enable;
    logic                  o_dot_enable;

    modport master (
        output i_value, i_load, i_hex_mode, i_dots,
        input  o_busy, o_overflow, o_segment_enable, o_display_enable, o_dot_enable
    );

    modport slave (
        input  i_value, i_load, i_hex_mode, i_dots,
        output o_busy, o_overflow, o_segment_enable, o_display_enable, o_dot_enable
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed active-low 7-segment driver: sequential double-dabble (or hex
// pass-through) into a tear-free display register, then a refresh-rate digit scanner.
module seg7_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int BIN_WIDTH     = 14,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic              clk,
    input  logic              i_reset,
    seg7_scan_driver_if.slave bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] DEC_MAX = pow10(NUM_DIGITS) - 64'd1;

    function automatic logic [0:6] decode(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_e;

    state_e                     state_q, state_d;
    logic                       latch_en, step_en, commit_en;
    logic [BIN_WIDTH-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]           bcd_q, bcd_d, bcd_adj;
    logic [BCD_W+BIN_WIDTH-1:0] shifted;
    logic [CNT_W-1:0]           cnt_q;
    logic                       hex_q, ovf_pend_q, load_ovf;
    logic [BCD_W-1:0]           disp_q;
    logic                       disp_ovf_q;

    logic [REF_W-1:0]           ref_q;
    logic [IDX_W-1:0]           idx_q;
    logic [3:0]                 nib;
    logic                       upper_zero;
    logic [0:6]                 seg_d, seg_q;
    logic [0:NUM_DIGITS-1]      an_d, an_q;
    logic                       dot_q;

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_load) state_d = CONVERT;
            CONVERT: if (hex_q || cnt_q == CNT_W'(BIN_WIDTH - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        latch_en  = (state_q == IDLE) && bus.i_load;
        step_en   = (state_q == CONVERT);
        commit_en = (state_q == COMMIT);
    end

    assign bus.o_busy = (state_q != IDLE);

    // Overflow is judged against the raw value, before any conversion happens.
    assign load_ovf = bus.i_hex_mode ? |(bus.i_value >> BCD_W)
                                     : (64'(bus.i_value) > DEC_MAX);

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin_q} << 1;
        if (hex_q) begin
            bcd_d = BCD_W'(bin_q);
            bin_d = bin_q;
        end else begin
            bcd_d = shifted[BCD_W+BIN_WIDTH-1 -: BCD_W];
            bin_d = shifted[BIN_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            hex_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            if (latch_en) begin
                bin_q      <= bus.i_value;
                bcd_q      <= '0;
                cnt_q      <= '0;
                hex_q      <= bus.i_hex_mode;
                ovf_pend_q <= load_ovf;
            end else if (step_en) begin
                bin_q <= bin_d;
                bcd_q <= bcd_d;
                cnt_q <= cnt_q + 1'b1;
            end
            // The display register only changes here, so the scan never shows a partial result.
            if (commit_en) begin
                disp_q     <= bcd_q;
                disp_ovf_q <= ovf_pend_q;
            end
        end
    end

    always_comb begin
        nib        = 4'd0;
        upper_zero = 1'b1;
        an_d       = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                nib     = disp_q[4*i +: 4];
                an_d[i] = 1'b0;
            end
            if (IDX_W'(i) >= idx_q && disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        if (disp_ovf_q)                                               seg_d = 7'b1111110;
        else if (BLANK_LEADING != 0 && idx_q != '0 && upper_zero)     seg_d = 7'b1111111;
        else                                                          seg_d = decode(nib);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            ref_q <= '0;
            idx_q <= '0;
            seg_q <= '1;
            an_q  <= '1;
            dot_q <= 1'b1;
        end else begin
            if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
                ref_q <= '0;
                idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
            dot_q <= ~bus.i_dots[idx_q];
        end
    end

    assign bus.o_overflow       = disp_ovf_q;
    assign bus.o_segment_enable = seg_q;
    assign bus.o_display_enable = an_q;
    assign bus.o_dot_enable     = dot_q;
endmodule
